// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
// Shared definitions for the serial pattern sequence generator:
//   - default pattern length and counter width
//   - FSM state encoding used by sequence_generator
// -----------------------------------------------------------------------------
package seq_gen_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_piso.sv
// -----------------------------------------------------------------------------
// seq_piso
// Parallel-in / serial-out shift register, MSB-first.
// Ports:
//   i_clk    - clock
//   i_reset  - asynchronous active-high reset, clears the register
//   i_clear  - synchronous clear (highest synchronous priority)
//   i_load   - load i_d
//   i_shift  - shift left by one, zero fill
//   i_d      - parallel load value
//   o_msb    - current most significant bit (next serial bit)
// -----------------------------------------------------------------------------
module seq_piso #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sr;

    // Shift register: clear > load > shift > hold
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sr <= '0;
        end else if (i_clear) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_d;
        end else if (i_shift) begin
            r_sr <= {r_sr[WIDTH-2:0], 1'b0};
        end else begin
            r_sr <= r_sr;
        end
    end

    assign o_msb = r_sr[WIDTH-1];

endmodule

// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
// Sends a captured pattern MSB-first on a registered serial output, repeated
// rep+1 times with gap idle cycles between repetitions.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start           - begin a transmission (sampled in IDLE only)
//   abort           - cancel a transmission in SHIFT or GAP
//   pattern         - right-aligned bits to send
//   len, rep, gap   - bit count (clamped to MAX_LEN), extra repeats, gap cycles
//   w, w_valid      - serial bit and its qualifier
//   busy            - high from first to last bit (including gaps)
//   done            - one-cycle pulse after normal completion
// -----------------------------------------------------------------------------
module sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]   len,
    input  logic [CNT_W-1:0]   rep,
    input  logic [CNT_W-1:0]   gap,
    output logic               w,
    output logic               w_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

    // Left-justify the active len bits so the first bit to send sits at the MSB.
    function automatic logic [MAX_LEN-1:0] align_msb(input logic [MAX_LEN-1:0] p,
                                                     input logic [CNT_W-1:0]   l);
        return p << (MAX_LEN - int'(l));
    endfunction

    state_t               r_state;
    logic                 r_w;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_W-1:0]     r_bit_cnt;   // bits still to send after the current one
    logic [CNT_W-1:0]     r_rep_cnt;   // repetitions still to start
    logic [CNT_W-1:0]     r_gap_cnt;   // gap cycles still to wait after the current one
    logic [CNT_W-1:0]     r_len;
    logic [CNT_W-1:0]     r_gap;
    logic [MAX_LEN-1:0]   r_pat_al;    // captured, left-justified pattern for reloads

    logic                 w_start;
    logic [CNT_W-1:0]     w_len_eff;
    logic [MAX_LEN-1:0]   w_in_al;
    logic [MAX_LEN-1:0]   w_src;
    logic [MAX_LEN-1:0]   w_load_data;
    logic                 w_first_bit;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_clear;
    logic                 w_piso_msb;

    assign w_len_eff   = (len > LEN_MAX) ? LEN_MAX : len;
    assign w_start     = start && (len != '0);
    assign w_in_al     = align_msb(pattern, w_len_eff);
    // The first bit goes straight to w, so the shift register keeps only the rest.
    assign w_first_bit = w_src[MAX_LEN-1];
    assign w_load_data = {w_src[MAX_LEN-2:0], 1'b0};

    // Shift-register control, mirroring the state transitions below
    always_comb begin
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_clear = 1'b0;
        w_src   = r_pat_al;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_load = 1'b1;
                    w_src  = w_in_al;
                end else begin
                    w_load = 1'b0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_clear = 1'b1;
                end else if (r_bit_cnt != '0) begin
                    w_shift = 1'b1;
                end else if ((r_rep_cnt != '0) && (r_gap == '0)) begin
                    w_load = 1'b1;
                end else if (r_rep_cnt == '0) begin
                    w_clear = 1'b1;
                end else begin
                    w_load = 1'b0;
                end
            end
            GAP: begin
                if (abort) begin
                    w_clear = 1'b1;
                end else if (r_gap_cnt == '0) begin
                    w_load = 1'b1;
                end else begin
                    w_load = 1'b0;
                end
            end
            DONE: begin
                w_clear = 1'b0;
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
    end

    seq_piso #(
        .WIDTH (MAX_LEN)
    ) u_piso (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_d     (w_load_data),
        .o_msb   (w_piso_msb)
    );

    // Main FSM with counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_w       <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
            r_len     <= '0;
            r_gap     <= '0;
            r_pat_al  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_start) begin
                        r_state   <= SHIFT;
                        r_len     <= w_len_eff;
                        r_gap     <= gap;
                        r_rep_cnt <= rep;
                        r_bit_cnt <= w_len_eff - CNT_ONE;
                        r_pat_al  <= w_in_al;
                        r_w       <= w_first_bit;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_w     <= 1'b0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        r_state   <= IDLE;
                        r_w       <= 1'b0;
                        r_valid   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_rep_cnt <= '0;
                        r_gap_cnt <= '0;
                    end else if (r_bit_cnt != '0) begin
                        r_w       <= w_piso_msb;
                        r_bit_cnt <= r_bit_cnt - CNT_ONE;
                    end else if (r_rep_cnt != '0) begin
                        if (r_gap != '0) begin
                            r_state   <= GAP;
                            r_gap_cnt <= r_gap - CNT_ONE;
                            r_w       <= 1'b0;
                            r_valid   <= 1'b0;
                        end else begin
                            // Back-to-back repetition: no bubble between copies.
                            r_w       <= w_first_bit;
                            r_bit_cnt <= r_len - CNT_ONE;
                            r_rep_cnt <= r_rep_cnt - CNT_ONE;
                        end
                    end else begin
                        r_state <= DONE;
                        r_w     <= 1'b0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_rep_cnt <= '0;
                        r_gap_cnt <= '0;
                    end else if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - CNT_ONE;
                    end else begin
                        r_state   <= SHIFT;
                        r_w       <= w_first_bit;
                        r_valid   <= 1'b1;
                        r_bit_cnt <= r_len - CNT_ONE;
                        r_rep_cnt <= r_rep_cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_w     <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign w       = r_w;
    assign w_valid = r_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_sequence_generator.sv
// -----------------------------------------------------------------------------
// tb_sequence_generator
// Self-checking bench: each scenario task drives the DUT and compares the
// per-cycle tuple {w, w_valid, busy, done} against a queue built from the
// transmission rules (bits, gaps, done pulse, trailing idle cycle).
// -----------------------------------------------------------------------------
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'd0;
    logic [3:0] rep = 4'd0;
    logic [3:0] gap = 4'd0;
    logic       w, w_valid, busy, done;

    int passed = 0;
    int total  = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    sequence_generator dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .len     (len),
        .rep     (rep),
        .gap     (gap),
        .w       (w),
        .w_valid (w_valid),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [3:0] obs();
        return {w, w_valid, busy, done};
    endfunction

    // Expected cycles after the start edge: {w, w_valid, busy, done}
    task automatic build(input logic [7:0] p, input int l, input int r, input int g);
        int le;
        exp_q.delete();
        le = (l > 8) ? 8 : l;
        if (le == 0) begin
            exp_q.push_back(4'b0000);
            exp_q.push_back(4'b0000);
        end else begin
            for (int k = 0; k <= r; k++) begin
                for (int b = le - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
                if (k < r) for (int q = 0; q < g; q++) exp_q.push_back(4'b0010);
            end
            exp_q.push_back(4'b0001);
            exp_q.push_back(4'b0000);
        end
    endtask

    task automatic kick(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                        input logic [3:0] g);
        pattern = p; len = l; rep = r; gap = g; start = 1'b1;
    endtask

    // Garble the request inputs: a captured transmission must not notice.
    task automatic scramble();
        start   = 1'b0;
        pattern = 8'($urandom);
        len     = 4'($urandom);
        rep     = 4'($urandom);
        gap     = 4'($urandom);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        total++;
        if (obs() !== 4'b0000) $display("FAIL reset_async got=%b exp=%b", obs(), 4'b0000);
        else passed++;
        repeat (2) @(negedge clk);
        total++;
        if (obs() !== 4'b0000) $display("FAIL reset_held got=%b exp=%b", obs(), 4'b0000);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs() !== 4'b0000) $display("FAIL reset_idle got=%b exp=%b", obs(), 4'b0000);
        else passed++;
    endtask

    task automatic test_single();
        build(8'h0B, 4, 0, 0);
        kick(8'h0B, 4'd4, 4'd0, 4'd0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs() !== exp_q[i]) $display("FAIL single cyc%0d got=%b exp=%b", i, obs(), exp_q[i]);
            else passed++;
            scramble();
        end
    endtask

    task automatic test_repeat_gap();
        build(8'h05, 3, 1, 2);
        kick(8'h05, 4'd3, 4'd1, 4'd2);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs() !== exp_q[i]) $display("FAIL repeat_gap cyc%0d got=%b exp=%b", i, obs(), exp_q[i]);
            else passed++;
            scramble();
        end
    endtask

    task automatic test_back_to_back();
        build(8'h01, 1, 4, 0);
        kick(8'h01, 4'd1, 4'd4, 4'd0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs() !== exp_q[i]) $display("FAIL back_to_back cyc%0d got=%b exp=%b", i, obs(), exp_q[i]);
            else passed++;
            scramble();
        end
    endtask

    // Abort in the third bit cycle, then abort in the first gap cycle.
    // The first start is issued together with abort, which must not block it.
    task automatic test_abort();
        logic [7:0] ps[2] = '{8'hFF, 8'h03};
        int ls[2] = '{8, 2};
        int rs[2] = '{0, 1};
        int gs[2] = '{0, 3};
        for (int c = 0; c < 2; c++) begin
            build(ps[c], ls[c], rs[c], gs[c]);
            kick(ps[c], 4'(ls[c]), 4'(rs[c]), 4'(gs[c]));
            abort = (c == 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                total++;
                if (obs() !== exp_q[i]) $display("FAIL abort%0d_pre cyc%0d got=%b exp=%b", c, i, obs(), exp_q[i]);
                else passed++;
                scramble();
                abort = (i == 2);
            end
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                total++;
                if (obs() !== 4'b0000) $display("FAIL abort%0d_post cyc%0d got=%b exp=%b", c, i, obs(), 4'b0000);
                else passed++;
                abort = 1'b0;
            end
        end
    endtask

    task automatic test_ignored();
        // len=0: no activity
        build(8'hFF, 0, 3, 1);
        kick(8'hFF, 4'd0, 4'd3, 4'd1);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs() !== exp_q[i]) $display("FAIL len_zero cyc%0d got=%b exp=%b", i, obs(), exp_q[i]);
            else passed++;
            scramble();
        end
        // len=12 clamps to 8; start held high while busy and in DONE is ignored
        build(8'hC6, 12, 1, 1);
        kick(8'hC6, 4'd12, 4'd1, 4'd1);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs() !== exp_q[i]) $display("FAIL clamp_busy_start cyc%0d got=%b exp=%b", i, obs(), exp_q[i]);
            else passed++;
            scramble();
            start = (i < exp_q.size() - 1);
        end
    endtask

    task automatic test_random();
        logic [7:0] p;
        int l, r, g;
        repeat (25) begin
            p = 8'($urandom);
            l = $urandom_range(0, 15);
            r = $urandom_range(0, 3);
            g = $urandom_range(0, 3);
            build(p, l, r, g);
            kick(p, 4'(l), 4'(r), 4'(g));
            foreach (exp_q[i]) begin
                @(negedge clk);
                total++;
                if (obs() !== exp_q[i])
                    $display("FAIL random p=%h l=%0d r=%0d g=%0d cyc%0d got=%b exp=%b",
                             p, l, r, g, i, obs(), exp_q[i]);
                else passed++;
                scramble();
                // noise start only while the DUT is busy or in DONE
                if ((l != 0) && (i < exp_q.size() - 1)) start = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset_mid();
        build(8'hA5, 8, 2, 1);
        kick(8'hA5, 4'd8, 4'd2, 4'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (obs() !== exp_q[i]) $display("FAIL reset_mid_pre cyc%0d got=%b exp=%b", i, obs(), exp_q[i]);
            else passed++;
            scramble();
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs() !== 4'b0000) $display("FAIL reset_mid_async got=%b exp=%b", obs(), 4'b0000);
        else passed++;
        @(negedge clk);
        total++;
        if (obs() !== 4'b0000) $display("FAIL reset_mid_held got=%b exp=%b", obs(), 4'b0000);
        else passed++;
        reset = 1'b0;
        build(8'h96, 6, 1, 0);
        kick(8'h96, 4'd6, 4'd1, 4'd0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs() !== exp_q[i]) $display("FAIL reset_restart cyc%0d got=%b exp=%b", i, obs(), exp_q[i]);
            else passed++;
            scramble();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_gap();
        test_back_to_back();
        test_abort();
        test_ignored();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
